// File: rtl/alu_divider_if.sv
// Operand and result handshake bundle for the iterative divider.
// The i_signed wire exists only when ALU_DIV_SIGNED_EN is defined.
interface alu_divider_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
`ifdef ALU_DIV_SIGNED_EN
    logic             i_signed;
`endif
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_by_zero;

    modport slave (
`ifdef ALU_DIV_SIGNED_EN
        input  i_signed,
`endif
        input  i_valid,
        input  i_dividend,
        input  i_divisor,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_quotient,
        output o_remainder,
        output o_div_by_zero
    );

    modport master (
`ifdef ALU_DIV_SIGNED_EN
        output i_signed,
`endif
        output i_valid,
        output i_dividend,
        output i_divisor,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_quotient,
        input  o_remainder,
        input  o_div_by_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH+1 latency.
// Optional two's-complement mode enabled by defining ALU_DIV_SIGNED_EN.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef ALU_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic a_neg;
    logic b_neg;
`endif

    // Next-state, datapath step and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        // Partial remainder needs one extra bit after the shift
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        qbit   = ~trial[WIDTH];
        rem_nx = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {dvd_q[WIDTH-2:0], qbit};

`ifdef ALU_DIV_SIGNED_EN
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        a_neg  = bus.i_signed & bus.i_dividend[WIDTH-1];
        b_neg  = bus.i_signed & bus.i_divisor[WIDTH-1];
        a_mag  = a_neg ? -bus.i_dividend : bus.i_dividend;
        b_mag  = b_neg ? -bus.i_divisor  : bus.i_divisor;
        // Most-negative / -1 wraps back to itself here
        q_fix  = qneg_q ? -quo_nx : quo_nx;
        r_fix  = rneg_q ? -rem_nx : rem_nx;
`else
        a_mag  = bus.i_dividend;
        b_mag  = bus.i_divisor;
        q_fix  = quo_nx;
        r_fix  = rem_nx;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    if (bus.i_divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = bus.i_dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
`ifdef ALU_DIV_SIGNED_EN
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
`endif
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                dvd_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = q_fix;
                    rmd_d   = r_fix;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef ALU_DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign bus.o_ready       = (state_q == IDLE);
    assign bus.o_valid       = (state_q == DONE);
    assign bus.o_quotient    = quo_q;
    assign bus.o_remainder   = rmd_q;
    assign bus.o_div_by_zero = dbz_q;

endmodule
